// File: rtl/malu_sequencer.sv
// ---------------------------------------------------------------------------
// malu_sequencer
//
// Control and data-staging stage that sits directly in front of the matrix
// ALU. It accepts an operation command, collects byte-wide matrix elements
// into the ALU's 200-bit A/B operand buses (5x5 row-major layout, element
// (r,c) at bits [(r*5+c)*8 +: 8]), and pulses the ALU opcode. It then latches
// the ALU result and streams the n x n result elements back out over a
// valid/ready handshake.
//
// Ports
//   clk, rst              rising-edge clock, synchronous active-high reset
//   cmd_valid/cmd_ready   command handshake (ready only while idle)
//   cmd_op, cmd_n, cmd_f  opcode (1..6), dimension (2..5), scalar for op 6
//   in_valid/in_ready     operand element handshake, in_data row-major
//   A_flat, B_flat        packed operand buses to the ALU
//   n, f, opcode          registered dimension/scalar and opcode to the ALU
//   C_flat                combinational result bus from the ALU
//   out_valid/out_ready   result element handshake, out_data row-major
//   out_last              marks the final (n*n-th) result element
//   busy                  high whenever a command is in progress
//   err                   one-cycle pulse after a rejected command
// ---------------------------------------------------------------------------
module malu_sequencer (
   input  logic         clk,
   input  logic         rst,
   input  logic         cmd_valid,
   output logic         cmd_ready,
   input  logic [3:0]   cmd_op,
   input  logic [2:0]   cmd_n,
   input  logic [8:0]   cmd_f,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [7:0]   in_data,
   output logic [199:0] A_flat,
   output logic [199:0] B_flat,
   output logic [2:0]   n,
   output logic [8:0]   f,
   output logic [3:0]   opcode,
   input  logic [199:0] C_flat,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [7:0]   out_data,
   output logic         out_last,
   output logic         busy,
   output logic         err
);

   typedef enum logic [2:0] {
      IDLE,
      LOAD_A,
      LOAD_B,
      EXEC,
      CAPTURE,
      DRAIN
   } seqState_t;

   seqState_t      r_state;
   seqState_t      w_nextState;

   logic [3:0]     r_op;
   logic [2:0]     r_n;
   logic [8:0]     r_f;
   logic [199:0]   r_aFlat;
   logic [199:0]   r_bFlat;
   logic [199:0]   r_result;
   logic [2:0]     r_row;
   logic [2:0]     r_col;
   logic           r_err;

   logic           w_cmdLegal;
   logic           w_inFire;
   logic           w_outFire;
   logic           w_colWrap;
   logic           w_lastElem;
   logic [4:0]     w_elemIdx;
   logic [7:0]     w_bitBase;

   // Command legality, handshake strobes and the position of the element the
   // row/column counters currently point at. The same counters serve the
   // load phases and the drain phase, so one bit offset covers both.
   assign w_cmdLegal = (cmd_op >= 4'd1) && (cmd_op <= 4'd6) &&
                       (cmd_n >= 3'd2) && (cmd_n <= 3'd5);
   assign w_inFire   = in_valid && in_ready;
   assign w_outFire  = out_valid && out_ready;
   assign w_colWrap  = (r_col == (r_n - 3'd1));
   assign w_lastElem = w_colWrap && (r_row == (r_n - 3'd1));
   assign w_elemIdx  = 5'(r_row) * 5'd5 + 5'(r_col);
   assign w_bitBase  = {w_elemIdx, 3'b000};

   // State register; reset discards any transaction in flight.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_nextState;
      end
   end

   // Next-state logic. Unary ops (4..6) skip the B load phase. EXEC and
   // CAPTURE each last exactly one cycle so the ALU sees opcode rise from
   // zero and then has a stable cycle before its result is latched.
   always_comb begin
      w_nextState = r_state;
      case (r_state)
         IDLE: begin
            if (cmd_valid && w_cmdLegal) begin
               w_nextState = LOAD_A;
            end
         end
         LOAD_A: begin
            if (w_inFire && w_lastElem) begin
               w_nextState = (r_op <= 4'd3) ? LOAD_B : EXEC;
            end
         end
         LOAD_B: begin
            if (w_inFire && w_lastElem) begin
               w_nextState = EXEC;
            end
         end
         EXEC: begin
            w_nextState = CAPTURE;
         end
         CAPTURE: begin
            w_nextState = DRAIN;
         end
         DRAIN: begin
            if (w_outFire && w_lastElem) begin
               w_nextState = IDLE;
            end
         end
         default: begin
            w_nextState = IDLE;
         end
      endcase
   end

   // Command registers, operand buses, result latch and the error pulse.
   // Operand buses are cleared on command acceptance so that positions
   // outside the n x n window are always zero and nothing stale survives.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_op     <= 4'd0;
         r_n      <= 3'd0;
         r_f      <= 9'd0;
         r_aFlat  <= '0;
         r_bFlat  <= '0;
         r_result <= '0;
         r_err    <= 1'b0;
      end else begin
         r_err <= 1'b0;
         case (r_state)
            IDLE: begin
               if (cmd_valid) begin
                  if (w_cmdLegal) begin
                     r_op     <= cmd_op;
                     r_n      <= cmd_n;
                     r_f      <= cmd_f;
                     r_aFlat  <= '0;
                     r_bFlat  <= '0;
                     r_result <= '0;
                  end else begin
                     r_err <= 1'b1;
                  end
               end
            end
            LOAD_A: begin
               if (w_inFire) begin
                  r_aFlat[w_bitBase +: 8] <= in_data;
               end
            end
            LOAD_B: begin
               if (w_inFire) begin
                  r_bFlat[w_bitBase +: 8] <= in_data;
               end
            end
            CAPTURE: begin
               r_result <= C_flat;
            end
            default: begin
            end
         endcase
      end
   end

   // Row/column counters. They restart on command acceptance and advance
   // row-major on every load or drain handshake; wrapping after the last
   // element leaves them at (0,0) for the following phase.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_row <= 3'd0;
         r_col <= 3'd0;
      end else if ((r_state == IDLE) && cmd_valid && w_cmdLegal) begin
         r_row <= 3'd0;
         r_col <= 3'd0;
      end else if (w_inFire || w_outFire) begin
         if (w_colWrap) begin
            r_col <= 3'd0;
            r_row <= w_lastElem ? 3'd0 : (r_row + 3'd1);
         end else begin
            r_col <= r_col + 3'd1;
         end
      end
   end

   // Output decode. out_data only moves when the counters move, which keeps
   // it stable while the consumer stalls.
   assign cmd_ready = (r_state == IDLE);
   assign in_ready  = (r_state == LOAD_A) || (r_state == LOAD_B);
   assign busy      = (r_state != IDLE);
   assign out_valid = (r_state == DRAIN);
   assign out_last  = (r_state == DRAIN) && w_lastElem;
   assign out_data  = (r_state == DRAIN) ? r_result[w_bitBase +: 8] : 8'd0;
   assign opcode    = ((r_state == EXEC) || (r_state == CAPTURE)) ? r_op : 4'd0;
   assign A_flat    = r_aFlat;
   assign B_flat    = r_bFlat;
   assign n         = r_n;
   assign f         = r_f;
   assign err       = r_err;

endmodule

// File: tb/tb_malu_sequencer.sv
// ---------------------------------------------------------------------------
// tb_malu_sequencer
//
// Self-checking bench for malu_sequencer with a behavioural matrix ALU
// attached. Operands live in plain integer matrices; expected results are
// computed from those matrices with ordinary arithmetic and compared against
// the streamed output. Directed scenarios come first, then randomized
// commands with random input gaps and random output backpressure.
// ---------------------------------------------------------------------------
module tb_malu_sequencer;

   logic         clk;
   logic         rst;
   logic         cmd_valid;
   logic         cmd_ready;
   logic [3:0]   cmd_op;
   logic [2:0]   cmd_n;
   logic [8:0]   cmd_f;
   logic         in_valid;
   logic         in_ready;
   logic [7:0]   in_data;
   logic [199:0] A_flat;
   logic [199:0] B_flat;
   logic [2:0]   n;
   logic [8:0]   f;
   logic [3:0]   opcode;
   logic [199:0] C_flat;
   logic         out_valid;
   logic         out_ready;
   logic [7:0]   out_data;
   logic         out_last;
   logic         busy;
   logic         err;

   int numChecks = 0;
   int numFails  = 0;

   int matA [5][5];
   int matB [5][5];
   int expQ [$];

   malu_sequencer dut (
      .clk       (clk),
      .rst       (rst),
      .cmd_valid (cmd_valid),
      .cmd_ready (cmd_ready),
      .cmd_op    (cmd_op),
      .cmd_n     (cmd_n),
      .cmd_f     (cmd_f),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .A_flat    (A_flat),
      .B_flat    (B_flat),
      .n         (n),
      .f         (f),
      .opcode    (opcode),
      .C_flat    (C_flat),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_last  (out_last),
      .busy      (busy),
      .err       (err)
   );

   // Free-running clock, 10 ns period.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Behavioural ALU: produces nothing while opcode is zero, so a missing
   // or mistimed opcode shows up as wrong results.
   function automatic logic [199:0] aluModel(input logic [199:0] a,
                                             input logic [199:0] b,
                                             input logic [3:0]   op,
                                             input logic [2:0]   nn,
                                             input logic [8:0]   ff);
      logic [199:0] res;
      int v;
      int av;
      int bv;
      res = '0;
      for (int r = 0; r < 5; r++) begin
         for (int c = 0; c < 5; c++) begin
            if (r < int'(nn) && c < int'(nn)) begin
               av = int'($signed(a[(r*5+c)*8 +: 8]));
               bv = int'($signed(b[(r*5+c)*8 +: 8]));
               case (op)
                  4'd1: v = av + bv;
                  4'd2: v = av - bv;
                  4'd3: begin
                     v = 0;
                     for (int k = 0; k < int'(nn); k++) begin
                        v += int'($signed(a[(r*5+k)*8 +: 8])) *
                             int'($signed(b[(k*5+c)*8 +: 8]));
                     end
                  end
                  4'd4: v = int'($signed(a[(c*5+r)*8 +: 8]));
                  4'd5: v = -av;
                  4'd6: v = av * int'($signed(ff));
                  default: v = 0;
               endcase
               res[(r*5+c)*8 +: 8] = v[7:0];
            end
         end
      end
      return res;
   endfunction

   assign C_flat = aluModel(A_flat, B_flat, opcode, n, f);

   // Reference result for one element, from the integer operand matrices.
   function automatic int refElem(input int op, input int nn, input int ff,
                                  input int r, input int c);
      int v;
      case (op)
         1: v = matA[r][c] + matB[r][c];
         2: v = matA[r][c] - matB[r][c];
         3: begin
            v = 0;
            for (int k = 0; k < nn; k++) v += matA[r][k] * matB[k][c];
         end
         4: v = matA[c][r];
         5: v = -matA[r][c];
         6: v = matA[r][c] * ff;
         default: v = 0;
      endcase
      return v & 255;
   endfunction

   // Expected operand bus: the loaded n x n window, zero elsewhere.
   function automatic logic [199:0] packMatrix(input bit useB, input int nn);
      logic [199:0] res;
      int v;
      res = '0;
      for (int r = 0; r < nn; r++) begin
         for (int c = 0; c < nn; c++) begin
            v = useB ? matB[r][c] : matA[r][c];
            res[(r*5+c)*8 +: 8] = v[7:0];
         end
      end
      return res;
   endfunction

   // Single comparison point: counts every check and reports mismatches.
   task automatic checkOutput(input string tag, input logic [199:0] observed,
                              input logic [199:0] expected);
      numChecks++;
      if (observed !== expected) begin
         numFails++;
         $display("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
      end
   endtask

   // Advance one clock and settle just past the rising edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Offer one command for a single cycle.
   task automatic sendCmd(input int op, input int nn, input int ff);
      cmd_valid = 1'b1;
      cmd_op    = 4'(op);
      cmd_n     = 3'(nn);
      cmd_f     = 9'(ff);
      checkOutput("cmdReady before accept", cmd_ready, 1);
      tick();
      cmd_valid = 1'b0;
      cmd_op    = 4'($urandom_range(0, 15));
   endtask

   // Stream an n x n matrix row-major, optionally with idle gaps that carry
   // junk data.
   task automatic applyStimulus(input bit useB, input int nn, input bit gaps);
      for (int r = 0; r < nn; r++) begin
         for (int c = 0; c < nn; c++) begin
            if (gaps) begin
               while ($urandom_range(0, 2) == 0) begin
                  in_valid = 1'b0;
                  in_data  = 8'($urandom);
                  tick();
               end
            end
            in_valid = 1'b1;
            in_data  = 8'(useB ? matB[r][c] : matA[r][c]);
            checkOutput("inReady during load", in_ready, 1);
            tick();
            in_valid = 1'b0;
         end
      end
   endtask

   // One complete command: load, execute, drain with optional backpressure.
   task automatic runOp(input int op, input int nn, input int ff,
                        input bit gaps, input bit rndReady,
                        input int stallIdx, input int stallLen,
                        input bit chkLatency);
      int cnt;
      int idx;
      int cyc;
      int stallCnt;
      bit rdy;
      sendCmd(op, nn, ff);
      checkOutput("inReady after accept", in_ready, 1);
      checkOutput("busy after accept", busy, 1);
      applyStimulus(1'b0, nn, gaps);
      if (op <= 3) applyStimulus(1'b1, nn, gaps);
      checkOutput("exec opcode", opcode, op);
      checkOutput("exec inReady", in_ready, 0);
      checkOutput("A_flat layout", A_flat, packMatrix(1'b0, nn));
      checkOutput("B_flat layout", B_flat, (op <= 3) ? packMatrix(1'b1, nn) : 200'd0);
      checkOutput("n output", n, nn);
      checkOutput("f output", f, ff);
      cnt = 0;
      while (out_valid !== 1'b1 && cnt < 20) begin
         tick();
         cnt++;
      end
      if (out_valid !== 1'b1) begin
         checkOutput("first outValid timeout", out_valid, 1);
         return;
      end
      if (chkLatency) checkOutput("first outValid latency", cnt, 2);
      expQ.delete();
      for (int r = 0; r < nn; r++) begin
         for (int c = 0; c < nn; c++) expQ.push_back(refElem(op, nn, ff, r, c));
      end
      idx = 0;
      cyc = 0;
      stallCnt = 0;
      while (idx < nn * nn && cyc < nn * nn + 300) begin
         if (idx == stallIdx && stallCnt < stallLen) begin
            rdy = 1'b0;
            stallCnt++;
         end else if (rndReady) begin
            rdy = ($urandom_range(0, 3) != 0);
         end else begin
            rdy = 1'b1;
         end
         out_ready = rdy;
         checkOutput("outValid during drain", out_valid, 1);
         checkOutput("outData", out_data, expQ[idx]);
         checkOutput("outLast", out_last, (idx == nn * nn - 1));
         tick();
         if (rdy) idx++;
         cyc++;
      end
      out_ready = 1'b0;
      if (idx != nn * nn) checkOutput("drain timeout", idx, nn * nn);
      checkOutput("busy after drain", busy, 0);
      checkOutput("cmdReady after drain", cmd_ready, 1);
      checkOutput("outValid after drain", out_valid, 0);
      if (!rndReady && stallLen == 0) checkOutput("drain cycle count", cyc, nn * nn);
   endtask

   // Every output at its reset value.
   task automatic checkReset(input string tag);
      checkOutput({tag, " cmdReady"}, cmd_ready, 1);
      checkOutput({tag, " busy"}, busy, 0);
      checkOutput({tag, " inReady"}, in_ready, 0);
      checkOutput({tag, " outValid"}, out_valid, 0);
      checkOutput({tag, " outLast"}, out_last, 0);
      checkOutput({tag, " outData"}, out_data, 0);
      checkOutput({tag, " err"}, err, 0);
      checkOutput({tag, " opcode"}, opcode, 0);
      checkOutput({tag, " n"}, n, 0);
      checkOutput({tag, " f"}, f, 0);
      checkOutput({tag, " A_flat"}, A_flat, 0);
      checkOutput({tag, " B_flat"}, B_flat, 0);
   endtask

   // Rejected command: err pulses for exactly one cycle, block stays idle.
   task automatic checkIllegal(input string tag, input int op, input int nn);
      cmd_valid = 1'b1;
      cmd_op    = 4'(op);
      cmd_n     = 3'(nn);
      cmd_f     = 9'd0;
      tick();
      cmd_valid = 1'b0;
      checkOutput({tag, " err pulse"}, err, 1);
      checkOutput({tag, " busy"}, busy, 0);
      checkOutput({tag, " cmdReady"}, cmd_ready, 1);
      tick();
      checkOutput({tag, " err cleared"}, err, 0);
      checkOutput({tag, " still idle"}, busy, 0);
   endtask

   task automatic clearMats();
      for (int r = 0; r < 5; r++) begin
         for (int c = 0; c < 5; c++) begin
            matA[r][c] = 0;
            matB[r][c] = 0;
         end
      end
   endtask

   // Hard stop if something hangs outside the bounded waits.
   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: simulation did not finish");
      $fatal(1, "[TB] watchdog expired");
   end

   // Main sequence: directed scenarios followed by randomized commands.
   initial begin
      rst       = 1'b1;
      cmd_valid = 1'b0;
      cmd_op    = 4'd0;
      cmd_n     = 3'd0;
      cmd_f     = 9'd0;
      in_valid  = 1'b0;
      in_data   = 8'd0;
      out_ready = 1'b0;
      tick();
      tick();
      checkReset("reset");
      rst = 1'b0;
      tick();

      $display("[TB] add n=2");
      clearMats();
      for (int i = 0; i < 4; i++) begin
         matA[i/2][i%2] = i + 1;
         matB[i/2][i%2] = (i + 1) * 10;
      end
      runOp(1, 2, 0, 1'b0, 1'b0, -1, 0, 1'b1);

      $display("[TB] transpose n=3");
      clearMats();
      for (int i = 0; i < 9; i++) matA[i/3][i%3] = i + 1;
      runOp(4, 3, 0, 1'b0, 1'b0, -1, 0, 1'b1);

      $display("[TB] multiply n=5");
      clearMats();
      for (int i = 0; i < 25; i++) begin
         matA[i/5][i%5] = (i/5 == i%5) ? 1 : 0;
         matB[i/5][i%5] = i + 1;
      end
      runOp(3, 5, 0, 1'b0, 1'b0, -1, 0, 1'b1);

      $display("[TB] illegal commands");
      checkIllegal("n=6", 1, 6);
      checkIllegal("op=0", 0, 3);
      clearMats();
      for (int i = 0; i < 4; i++) begin
         matA[i/2][i%2] = i + 5;
         matB[i/2][i%2] = 2 * i;
      end
      runOp(1, 2, 0, 1'b0, 1'b0, -1, 0, 1'b1);

      $display("[TB] scalar multiply with stall");
      clearMats();
      for (int i = 0; i < 4; i++) matA[i/2][i%2] = i + 1;
      runOp(6, 2, 3, 1'b0, 1'b0, 1, 5, 1'b1);

      $display("[TB] reset during B load");
      clearMats();
      for (int i = 0; i < 9; i++) begin
         matA[i/3][i%3] = 50 + i;
         matB[i/3][i%3] = 90 + i;
      end
      sendCmd(1, 3, 7);
      applyStimulus(1'b0, 3, 1'b0);
      for (int i = 0; i < 2; i++) begin
         in_valid = 1'b1;
         in_data  = 8'(matB[0][i]);
         tick();
      end
      in_valid = 1'b0;
      rst = 1'b1;
      tick();
      rst = 1'b0;
      checkReset("mid-load reset");
      clearMats();
      for (int i = 0; i < 4; i++) begin
         matA[i/2][i%2] = 3 * i + 1;
         matB[i/2][i%2] = 7 - i;
      end
      runOp(1, 2, 0, 1'b0, 1'b0, -1, 0, 1'b1);

      $display("[TB] randomized commands");
      for (int t = 0; t < 10; t++) begin
         int op;
         int nn;
         int ff;
         op = int'($urandom_range(1, 6));
         nn = int'($urandom_range(2, 5));
         ff = int'($urandom_range(0, 20));
         clearMats();
         for (int r = 0; r < nn; r++) begin
            for (int c = 0; c < nn; c++) begin
               matA[r][c] = int'($urandom_range(0, 255)) - 128;
               matB[r][c] = int'($urandom_range(0, 255)) - 128;
            end
         end
         runOp(op, nn, ff, 1'b1, 1'b1, -1, 0, 1'b1);
         repeat ($urandom_range(0, 3)) tick();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", numChecks, numFails);
      $finish;
   end

endmodule

// File: doc/malu_sequencer.md
# malu_sequencer

Control and data-staging stage directly upstream of the matrix ALU. It accepts an operation command and byte-wide matrix element streams, and packs the elements into the ALU's 200-bit A/B operand buses using the 5×5 row-major layout. It drives the ALU's opcode, n and f inputs, captures the combinational result, and streams the n×n result back out element by element over a valid/ready handshake.

## Interface
Parameters: none. The geometry is fixed at 5×5 signed 8-bit elements.

- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- cmd_valid  in  1  command offered
- cmd_ready  out  1  high only in IDLE
- cmd_op  in  4  ALU opcode; legal values 1..6
- cmd_n  in  3  matrix dimension; legal values 2..5
- cmd_f  in  9  scalar for opcode 6
- in_valid  in  1  element offered
- in_ready  out  1  high only in LOAD_A and LOAD_B
- in_data  in  8  element, row-major
- A_flat  out  200  to ALU; element (r,c) occupies bits [(r*5+c)*8 +: 8]
- B_flat  out  200  to ALU; same layout as A_flat
- n  out  3  to ALU; registered cmd_n
- f  out  9  to ALU; registered cmd_f
- opcode  out  4  to ALU; 4'b0000 except in EXEC and CAPTURE
- C_flat  in  200  from ALU; same layout as A_flat
- out_valid  out  1  result element valid
- out_ready  in  1  consumer accepts
- out_data  out  8  result element, row-major
- out_last  out  1  high with the final (n*n-th) element
- busy  out  1  high whenever state is not IDLE
- err  out  1  one-cycle pulse on a rejected command

## Operation
- States: IDLE, LOAD_A, LOAD_B, EXEC, CAPTURE, DRAIN.
- IDLE, cmd_valid=1:
  - If cmd_op is not in 1..6, or cmd_n is not in 2..5: pulse err for one cycle and stay in IDLE. The command is consumed.
  - Otherwise: register op, n and f; clear A_flat, B_flat and the result register to 0; reset the row/column counters; go to LOAD_A.
- LOAD_A:
  - Each in_valid&&in_ready handshake writes A(r,c).
  - c increments; when c reaches n-1 it wraps to 0 and r increments.
  - After element (n-1,n-1): go to LOAD_B if op ∈ {1,2,3}, else go to EXEC. Counters reset in both cases.
- LOAD_B: same as LOAD_A, writing B(r,c). After element (n-1,n-1): go to EXEC.
- Positions with r≥n or c≥n remain 0 in both operand buses.
- EXEC: drive opcode=op for one cycle. The ALU re-evaluates on an opcode change, so opcode must transition from 0 to op here.
- CAPTURE: keep opcode=op and latch C_flat into the result register at the clock edge. Then go to DRAIN.
- DRAIN:
  - out_valid=1; out_data = result(r,c), row-major over n×n.
  - On each out_valid&&out_ready, advance (r,c).
  - out_last=1 exactly when (r,c)=(n-1,n-1).
  - The handshake on the last element returns the block to IDLE.
- Hold rule: out_data and out_last stay stable while out_valid=1 and out_ready=0.
- Arithmetic: none in this block. Results are whatever the ALU produces, truncated to 8 bits per element.
- in_valid is ignored outside the load states; cmd_valid is ignored outside IDLE.

## Timing
- Reset values: all outputs 0, except cmd_ready=1 (state IDLE). A_flat, B_flat and the result register clear. opcode=0, n=0, f=0.
- rst asserted in any state, including mid-load or mid-drain: the next state is IDLE and the partial data is discarded.
- Command accepted at cycle T → LOAD_A begins at T+1, with in_ready=1 from T+1.
- Last operand element accepted at cycle L → EXEC at L+1, CAPTURE at L+2, first out_valid at L+3.
- Drain with out_ready held at 1 delivers n*n elements in n*n consecutive cycles.
- The next command can be accepted one cycle after the last drain handshake.
- err is a single-cycle pulse in the cycle after the rejected cmd_valid; cmd_ready stays 1.

## Test plan
The bench instantiates this block with the ALU attached.

1. **Add, n=2:** A=1,2,3,4; B=10,20,30,40 → out 11,22,33,44 with out_last on the 4th element; A_flat bits [47:40] = 8'd3 (row 1, column 0).
2. **Transpose, n=3:** op=4, A=1..9, no B phase (in_ready drops after 9 elements) → out 1,4,7,2,5,8,3,6,9.
3. **Multiply, n=5:** A=identity, B=1..25 → out 1..25. Also check first out_valid arrives exactly 3 cycles after the last B handshake.
4. **Illegal commands:** cmd_n=6 → err pulse, state stays IDLE, busy=0. Then cmd_op=0 → err pulse. A subsequent legal command proceeds normally.
5. **Output backpressure:** drive out_ready low for 5 cycles on the 2nd element of a scalar multiply (op=6, f=3, n=2, A=1,2,3,4) → out_data holds 6 throughout the stall; full sequence is 3,6,9,12.
6. **Reset mid-LOAD_B:** assert rst after 2 B elements → IDLE next cycle, all outputs at reset values. A following add command produces correct results, with no stale operand data.
